testio_target: RTL

- Slave/responder end of the single-bit test-IO serial link; pairs with the existing test-IO bus master.
- Deserialises host read/write frames from ti_dat_i and issues each as one request on the mem_if request/response interface.
- Serialises ACK/NACK and read data back to the host on ti_dat_o/ti_dat_oen.
- Sits in the chip test path between the pad-level test-IO pins and the on-chip memory NoC.

---
 rtl/testio_target.sv | 218 +++++++++++++++++++++
 1 files changed

// File: rtl/testio_target.sv
// Responder end of the single-bit test-IO link: deserialises host frames, issues one mem_if request per frame,
// and serialises ACK/NACK plus read data back. mem_if_req is held until mem_if_req_ready; the response wait is bounded by MEM_TIMEOUT.
module testio_target #(
  parameter logic [3:0] SRCID       = 4'hE,
  parameter int         TURN_CYC    = 2,
  parameter int         MEM_TIMEOUT = 1024
) (
  input  logic        ti_clk_i,
  input  logic        ti_rst_i,
  input  logic        ti_dat_i,
  output logic        ti_dat_o,
  output logic        ti_dat_oen,
  output logic        ti_err_o,
  output logic        mem_if_req_valid,
  input  logic        mem_if_req_ready,
  output logic [86:0] mem_if_req,
  input  logic        mem_if_resp_valid,
  output logic        mem_if_resp_ready,
  input  logic [50:0] mem_if_resp
);

  typedef enum logic [3:0] {
    IDLE, RX_TYPE, RX_ADDR, RX_STRB, RX_DATA, RX_PAR, RX_STOP,
    MEM_REQ, MEM_WAIT, TURN, TX_START, TX_ACK, TX_DATA, TX_PAR, TX_STOP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;

  logic [5:0]  r_cnt;
  logic [15:0] r_tmo;
  logic        r_type;
  logic [31:0] r_addr;
  logic [3:0]  r_strb;
  logic [31:0] r_data;
  logic [31:0] r_rdata;
  logic        r_rx_par;
  logic        r_nack;
  logic        r_tx_par;
  logic [7:0]  r_seq;
  logic [15:0] r_tid;
  logic        r_err;
  logic        r_dat_o;
  logic        r_dat_oen;

  logic [15:0] w_tid_now;
  logic        w_resp_match;
  logic        w_tmo_hit;
  logic        w_turn_done;
  logic        w_send_data;
  logic        w_dat_nxt;
  logic        w_oen_nxt;
  logic        w_unused_resp_type;

  assign w_tid_now    = {SRCID, 4'h0, r_seq};
  assign w_resp_match = mem_if_resp_valid && (mem_if_resp[47:32] == r_tid);
  assign w_tmo_hit    = (r_tmo == 16'(MEM_TIMEOUT - 1));
  assign w_turn_done  = (r_cnt == 6'(TURN_CYC - 1));
  assign w_send_data  = ~r_type & ~r_nack;
  assign w_unused_resp_type = ^mem_if_resp[50:48];

  always_ff @(posedge ti_clk_i or posedge ti_rst_i) begin
    if (ti_rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_dat_nxt   = 1'b1;
    w_oen_nxt   = 1'b1;
    case (r_state)
      IDLE:     if (!ti_dat_i) w_state_nxt = RX_TYPE;
      RX_TYPE:  w_state_nxt = RX_ADDR;
      RX_ADDR:  if (r_cnt == 6'd31) w_state_nxt = r_type ? RX_STRB : RX_PAR;
      RX_STRB:  if (r_cnt == 6'd3) w_state_nxt = RX_DATA;
      RX_DATA:  if (r_cnt == 6'd31) w_state_nxt = RX_PAR;
      RX_PAR:   w_state_nxt = RX_STOP;
      // running parity must be even and the stop bit high, otherwise NACK without touching memory
      RX_STOP:  w_state_nxt = (r_rx_par || !ti_dat_i) ? TURN : MEM_REQ;
      MEM_REQ:  if (mem_if_req_ready) w_state_nxt = MEM_WAIT;
      MEM_WAIT: if (w_resp_match || w_tmo_hit) w_state_nxt = TURN;
      TURN:     if (w_turn_done) w_state_nxt = TX_START;
      TX_START: begin
        w_state_nxt = TX_ACK;
        w_dat_nxt   = 1'b0;
        w_oen_nxt   = 1'b0;
      end
      TX_ACK: begin
        w_state_nxt = w_send_data ? TX_DATA : TX_PAR;
        w_dat_nxt   = ~r_nack;
        w_oen_nxt   = 1'b0;
      end
      TX_DATA: begin
        if (r_cnt == 6'd31) w_state_nxt = TX_PAR;
        w_dat_nxt = r_rdata[31];
        w_oen_nxt = 1'b0;
      end
      TX_PAR: begin
        w_state_nxt = TX_STOP;
        w_dat_nxt   = r_tx_par;
        w_oen_nxt   = 1'b0;
      end
      TX_STOP: begin
        w_state_nxt = IDLE;
        w_oen_nxt   = 1'b0;
      end
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ti_clk_i or posedge ti_rst_i) begin
    if (ti_rst_i) begin
      r_cnt    <= '0;
      r_tmo    <= '0;
      r_type   <= 1'b0;
      r_addr   <= '0;
      r_strb   <= '0;
      r_data   <= '0;
      r_rdata  <= '0;
      r_rx_par <= 1'b0;
      r_nack   <= 1'b0;
      r_tx_par <= 1'b0;
      r_seq    <= '0;
      r_tid    <= '0;
      r_err    <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_cnt    <= '0;
          r_rx_par <= 1'b0;
          r_nack   <= 1'b0;
        end
        RX_TYPE: begin
          r_type   <= ti_dat_i;
          r_rx_par <= r_rx_par ^ ti_dat_i;
        end
        RX_ADDR: begin
          r_addr   <= {r_addr[30:0], ti_dat_i};
          r_rx_par <= r_rx_par ^ ti_dat_i;
          r_cnt    <= (r_cnt == 6'd31) ? 6'd0 : r_cnt + 6'd1;
        end
        RX_STRB: begin
          r_strb   <= {r_strb[2:0], ti_dat_i};
          r_rx_par <= r_rx_par ^ ti_dat_i;
          r_cnt    <= (r_cnt == 6'd3) ? 6'd0 : r_cnt + 6'd1;
        end
        RX_DATA: begin
          r_data   <= {r_data[30:0], ti_dat_i};
          r_rx_par <= r_rx_par ^ ti_dat_i;
          r_cnt    <= (r_cnt == 6'd31) ? 6'd0 : r_cnt + 6'd1;
        end
        RX_PAR: r_rx_par <= r_rx_par ^ ti_dat_i;
        RX_STOP: begin
          r_cnt <= '0;
          if (r_rx_par || !ti_dat_i) r_nack <= 1'b1;
        end
        MEM_REQ: begin
          if (mem_if_req_ready) begin
            r_tid <= w_tid_now;
            r_seq <= r_seq + 8'd1;
            r_tmo <= '0;
          end
        end
        // responses with a foreign tid are consumed here and simply ignored
        MEM_WAIT: begin
          r_cnt <= '0;
          if (w_resp_match) begin
            r_rdata <= mem_if_resp[31:0];
          end else if (w_tmo_hit) begin
            r_nack <= 1'b1;
          end else begin
            r_tmo <= r_tmo + 16'd1;
          end
        end
        TURN: begin
          if (w_turn_done) begin
            r_cnt    <= '0;
            r_tx_par <= ~r_nack ^ (w_send_data & (^r_rdata));
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        TX_START: r_err <= r_nack;
        TX_DATA: begin
          r_rdata <= {r_rdata[30:0], 1'b0};
          r_cnt   <= r_cnt + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // line outputs change on the falling edge so each bit is centred on the host's rising-edge sample
  always_ff @(negedge ti_clk_i or posedge ti_rst_i) begin
    if (ti_rst_i) begin
      r_dat_o   <= 1'b1;
      r_dat_oen <= 1'b1;
    end else begin
      r_dat_o   <= w_dat_nxt;
      r_dat_oen <= w_oen_nxt;
    end
  end

  assign ti_dat_o          = r_dat_o;
  assign ti_dat_oen        = r_dat_oen;
  assign ti_err_o          = r_err;
  assign mem_if_req_valid  = (r_state == MEM_REQ);
  assign mem_if_resp_ready = (r_state == MEM_WAIT);
  assign mem_if_req        = mem_if_req_valid ?
                             {2'b00, r_type, w_tid_now, r_addr,
                              r_type ? r_strb : 4'hF,
                              r_type ? r_data : 32'h0} : '0;

endmodule
